// File: rtl/riscv_pkg.sv
// Shared front-end definitions: instruction width, canonical NOP and fetch FSM states.
package riscv_pkg;

    localparam int                 INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

    function automatic logic [31:0] pc_inc(input logic [31:0] p);
        return p + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer for fetched {pc, instr} entries; DEPTH must be a power of two.
// Flush wins over push/pop; a push into a full buffer is accepted only alongside a pop.
module fetch_fifo #(
    parameter int DEPTH  = 2,
    parameter int DATA_W = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop,
    input  logic                       flush,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [DATA_W-1:0]          head
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     cnt;
    logic              do_push, do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = cnt;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage is data only; validity is carried entirely by the pointers/count.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: sequential PC generation, one-cycle memory, decoupling buffer to decode.
// Optional misaligned-target fault entry enabled by FETCH_MISALIGN_CHECK_EN.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [31:0]        pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    output logic               if_valid,
    input  logic               if_ready,
    output logic [INSTR_W-1:0] if_instr,
    output logic [31:0]        if_pc
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic               if_fault
`endif
);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam int          CW1     = CW + 1;
    localparam int          EW      = 32 + INSTR_W;
    localparam logic [CW:0] DEPTH_U = CW1'(FIFO_DEPTH);

    function automatic logic [31:0] align_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_CHECK_EN
        return t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    fetch_state_e   state, state_nxt;
    logic           req_v, can_issue, pop;
    logic           vld_p1;
    logic [31:0]    pc_p1;
    logic           fifo_full, fifo_empty;
    logic [CW-1:0]  occ;
    logic [EW-1:0]  head;
    logic [CW:0]    used_now, used_nxt;

    // Slots committed = buffered + response in flight. A request may also be issued into
    // the last slot when decode is popping this cycle, which keeps streaming bubble-free.
    assign pop       = !fifo_empty && if_ready;
    assign used_now  = CW1'(occ) + CW1'(vld_p1);
    assign can_issue = (!fifo_full && (used_now < DEPTH_U)) || pop;
    assign req_v     = (state == ST_RUN) && can_issue;
    assign used_nxt  = used_now + CW1'(req_v) - CW1'(pop);

`ifdef FETCH_MISALIGN_CHECK_EN
    logic fault_pend, fault_lock, misaligned;

    assign misaligned = |redirect_pc[1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fault_pend <= 1'b0;
            fault_lock <= 1'b0;
        end else if (redirect_valid) begin
            fault_pend <= misaligned;
            fault_lock <= misaligned;
        end else if (fault_pend && if_ready) begin
            fault_pend <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:          state_nxt = ST_RUN;
            ST_RUN, ST_HOLD:  state_nxt = ((used_nxt < DEPTH_U) || if_ready) ? ST_RUN : ST_HOLD;
            default:          state_nxt = ST_IDLE;
        endcase
`ifdef FETCH_MISALIGN_CHECK_EN
        if (fault_lock)     state_nxt = ST_HOLD;
        if (redirect_valid) state_nxt = misaligned ? ST_HOLD : ST_RUN;
`else
        if (redirect_valid) state_nxt = ST_RUN;
`endif
    end

    // ---- p0: request stage (pc presented to memory)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            pc     <= RESET_PC;
            vld_p1 <= 1'b0;
        end else begin
            state  <= state_nxt;
            vld_p1 <= req_v && !redirect_valid;
            if (redirect_valid)
                pc <= align_target(redirect_pc);
            else if (req_v)
                pc <= pc_inc(pc);
        end
    end

    // ---- p1: response stage (instr returns for pc_p1)
    always_ff @(posedge clk) begin
        if (req_v) pc_p1 <= pc;
    end

    fetch_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (EW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (vld_p1),
        .push_data ({pc_p1, instr}),
        .pop       (pop),
        .flush     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (occ),
        .head      (head)
    );

    // ---- p2: buffered output to decode
`ifdef FETCH_MISALIGN_CHECK_EN
    assign if_valid = fault_pend || !fifo_empty;
    assign if_instr = fault_pend ? NOP_INSTR : (fifo_empty ? '0 : head[INSTR_W-1:0]);
    assign if_pc    = fault_pend ? pc        : (fifo_empty ? '0 : head[EW-1:INSTR_W]);
    assign if_fault = fault_pend;
`else
    assign if_valid = !fifo_empty;
    assign if_instr = fifo_empty ? '0 : head[INSTR_W-1:0];
    assign if_pc    = fifo_empty ? '0 : head[EW-1:INSTR_W];
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch (default RESET_PC=0, FIFO_DEPTH=2) with a one-cycle memory model.
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc, instr, redirect_pc, if_instr, if_pc;
    logic        redirect_valid, if_valid, if_ready;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        if_fault;
`endif
    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    logic [31:0] got [3];
    int          got_n;

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    always @(posedge clk) instr <= word(pc);

    instr_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .instr          (instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .if_fault       (if_fault)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the end, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        if_ready       = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;

        // Power-on reset, decode always ready
        rst_n = 1'b0;
        tick; tick;
        chk1("rst_valid", if_valid, 1'b0);
        chk ("rst_pc",    pc,       32'h0);
        chk ("rst_if_pc", if_pc,    32'h0);
        chk ("rst_instr", if_instr, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
        chk1("rst_fault", if_fault, 1'b0);
`endif
        rst_n = 1'b1;                       // IDLE cycle
        chk1("idle_valid", if_valid, 1'b0);
        chk ("idle_pc",    pc,       32'h0);
        tick;                               // first RUN cycle
        chk1("run0_valid", if_valid, 1'b0);
        chk ("run0_pc",    pc,       32'h0);
        tick;
        chk1("run1_valid", if_valid, 1'b0);
        chk ("run1_pc",    pc,       32'h4);
        tick;                               // two cycles after IDLE: first instruction
        for (int k = 0; k < 8; k++) begin
            chk1("stream_valid", if_valid, 1'b1);
            chk ("stream_if_pc", if_pc,    32'(4 * k));
            chk ("stream_instr", if_instr, word(32'(4 * k)));
            chk ("stream_pc",    pc,       32'(4 * k + 8));
            tick;
        end

        // Reset asserted mid-stream acts immediately
        rst_n = 1'b0;
        #1;
        chk1("midrst_valid", if_valid, 1'b0);
        chk ("midrst_pc",    pc,       32'h0);
        chk ("midrst_if_pc", if_pc,    32'h0);
        chk ("midrst_instr", if_instr, 32'h0);
        tick; tick;

        // Backpressure from the first cycle: two fetches then stall
        if_ready = 1'b0;
        rst_n    = 1'b1;
        tick; tick; tick;
        for (int k = 0; k < 5; k++) begin
            chk1("bp_valid", if_valid, 1'b1);
            chk ("bp_if_pc", if_pc,    32'h0);
            chk ("bp_pc",    pc,       32'h8);
            tick;
        end
        if_ready = 1'b1;
        got_n    = 0;
        for (int c = 0; c < 12 && got_n < 3; c++) begin
            if (if_valid) begin
                got[got_n] = if_pc;
                got_n++;
            end
            tick;
        end
        chk("bp_count", got_n,  32'd3);
        chk("bp_ord0",  got[0], 32'h0);
        chk("bp_ord1",  got[1], 32'h4);
        chk("bp_ord2",  got[2], 32'h8);
        chk("bp_next",  if_pc,  32'hC);

        // Redirect while the buffer is full
        rst_n    = 1'b0;
        if_ready = 1'b0;
        tick; tick;
        rst_n = 1'b1;
        tick; tick; tick; tick;
        chk("full_if_pc", if_pc, 32'h0);
        chk("full_pc",    pc,    32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h10;
        tick;
        redirect_valid = 1'b0;
        chk1("rdf0_valid", if_valid, 1'b0);
        chk ("rdf0_pc",    pc,       32'h10);
        if_ready = 1'b1;
        tick;
        chk1("rdf1_valid", if_valid, 1'b0);
        tick;
        chk1("rdf2_valid", if_valid, 1'b1);
        chk ("rdf2_if_pc", if_pc,    32'h10);
        chk ("rdf2_instr", if_instr, word(32'h10));
        tick;
        chk ("rdf3_if_pc", if_pc,    32'h14);

        // Redirect in the same cycle as a handshake on 0x14
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        tick;
        redirect_valid = 1'b0;
        chk1("rdh0_valid", if_valid, 1'b0);
        tick;
        chk1("rdh1_valid", if_valid, 1'b0);
        tick;
        chk1("rdh2_valid", if_valid, 1'b1);
        chk ("rdh2_if_pc", if_pc,    32'h40);
        tick;
        chk ("rdh3_if_pc", if_pc,    32'h44);

        // Address wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFF8;
        tick;
        redirect_valid = 1'b0;
        tick; tick;
        chk ("wrap0_if_pc", if_pc,    32'hFFFF_FFF8);
        chk ("wrap0_instr", if_instr, word(32'hFFFF_FFF8));
        chk ("wrap0_pc",    pc,       32'h0);
        tick;
        chk ("wrap1_if_pc", if_pc,    32'hFFFF_FFFC);
        tick;
        chk1("wrap2_valid", if_valid, 1'b1);
        chk ("wrap2_if_pc", if_pc,    32'h0);
        chk ("wrap2_instr", if_instr, word(32'h0));

        // Misaligned redirect target
        redirect_valid = 1'b1;
        redirect_pc    = 32'h6;
        tick;
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        chk1("mis0_valid", if_valid, 1'b1);
        chk1("mis0_fault", if_fault, 1'b1);
        chk ("mis0_instr", if_instr, 32'h0000_0013);
        chk ("mis0_if_pc", if_pc,    32'h6);
        chk ("mis0_pc",    pc,       32'h6);
        tick;
        chk1("mis1_valid", if_valid, 1'b0);
        chk ("mis1_pc",    pc,       32'h6);
        tick; tick;
        chk1("mis3_valid", if_valid, 1'b0);
        chk1("mis3_fault", if_fault, 1'b0);
        chk ("mis3_pc",    pc,       32'h6);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        tick;
        redirect_valid = 1'b0;
        tick; tick;
        chk1("mis_rec_valid", if_valid, 1'b1);
        chk ("mis_rec_if_pc", if_pc,    32'h20);
        chk ("mis_rec_instr", if_instr, word(32'h20));
        chk1("mis_rec_fault", if_fault, 1'b0);
`else
        chk1("mis0_valid", if_valid, 1'b0);
        chk ("mis0_pc",    pc,       32'h4);
        tick; tick;
        chk1("mis2_valid", if_valid, 1'b1);
        chk ("mis2_if_pc", if_pc,    32'h4);
        chk ("mis2_instr", if_instr, word(32'h4));
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset; multiple of 4.
REQ-002 Parameter FIFO_DEPTH, default 2: fetch buffer entries; allowed values are 2 and 4.
REQ-003 clk  input  1  single clock, all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 pc  output  32  fetch address to instruction memory.
REQ-006 instr  input  32  memory read data for the pc presented on the previous cycle (one-cycle read latency, no enable).
REQ-007 redirect_valid  input  1  branch/jump redirect strobe.
REQ-008 redirect_pc  input  32  redirect target.
REQ-009 if_valid  output  1  instruction available to decode.
REQ-010 if_ready  input  1  decode accepts the instruction; a transfer occurs when if_valid and if_ready are both high.
REQ-011 if_instr  output  32  instruction word.
REQ-012 if_pc  output  32  address of if_instr.
REQ-013 if_fault  output  1  misaligned target flag; exists only under the configuration macro (REQ-031).

Function
REQ-014 States: IDLE (first cycle after reset release), RUN, HOLD; req_v SHALL be high in RUN only.
REQ-015 IDLE -> RUN unconditionally; RUN -> HOLD when free slots (FIFO_DEPTH - occupancy - in-flight) would reach 0; HOLD -> RUN when a slot frees or on redirect.
REQ-016 In RUN, pc SHALL advance by 4 each cycle; in HOLD/IDLE pc SHALL hold.
REQ-017 A response SHALL be captured as {pc_d, instr} on the cycle after a RUN cycle, where pc_d is the registered pc.
REQ-018 The FIFO SHALL never overflow; in-flight plus occupancy SHALL be at most FIFO_DEPTH at all times.
REQ-019 if_valid SHALL be high iff the FIFO is non-empty; if_instr/if_pc SHALL be the head entry, stable while if_valid and !if_ready.
REQ-020 Latency: the first if_valid SHALL occur 2 cycles after the IDLE cycle, with if_pc=RESET_PC.
REQ-021 With if_ready held high, throughput SHALL be one instruction per cycle with no bubbles.
REQ-022 redirect_valid SHALL, on the same edge, flush the FIFO, kill the in-flight response, set pc=redirect_pc and enter RUN.
REQ-023 A redirect coinciding with a handshake SHALL take precedence; the consumed entry is discarded and no duplicate is produced.
REQ-024 The first instruction after a redirect SHALL appear 2 cycles after the redirect edge.
REQ-025 pc SHALL wrap from 32'hFFFF_FFFC to 32'h0000_0000 without a fault.
REQ-026 If a push and a pop occur in the same cycle with the FIFO full, both SHALL complete and occupancy SHALL stay unchanged.

Reset
REQ-027 On rst_n low, regardless of clk: pc=RESET_PC, state=IDLE, FIFO empty, in-flight cleared, if_valid=0, if_instr=0, if_pc=0, if_fault=0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered and in-flight instructions.
REQ-029 Deassertion SHALL be synchronized externally; the block does not synchronize rst_n internally.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHECK_EN selects misaligned-target checking.
REQ-031 When defined: a redirect_pc with bits[1:0] != 0 SHALL enter HOLD without fetching, present one entry {if_pc=redirect_pc, if_instr=32'h0000_0013, if_fault=1}, and stay in HOLD until the next redirect.
REQ-032 When undefined: redirect_pc[1:0] SHALL be forced to 0, the if_fault port SHALL be absent, and no fault logic SHALL be present.

Structure
REQ-033 The shared package riscv_pkg SHALL hold the NOP encoding (32'h0000_0013), the instruction-width localparam, and the fetch state enum.
REQ-034 The buffer SHALL be a sub-module fetch_fifo (push, pop, full, empty, flush) parameterized on depth and width.

Verification
REQ-035 Reset release with if_ready=1 -> if_pc sequence 0, 4, 8, ... with no gaps, and if_instr matching the preloaded memory word at each address.
REQ-036 Hold if_ready=0 for 5 cycles -> pc stalls after 2 fetches and if_pc=0 is stable; after release, entries 0, 4, 8 arrive in order with no loss or duplicates.
REQ-037 Redirect to 32'h10 while the FIFO is full -> the next if_pc is 32'h10 exactly 2 cycles later, and no stale entry appears.
REQ-038 Redirect coinciding with a handshake -> the handshake entry is consumed once, and the following entry is the target.
REQ-039 Redirect to 32'hFFFF_FFF8 -> if_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-040 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h6 -> if_fault=1, if_instr=32'h13, pc frozen until the next redirect; without the macro, the same redirect -> if_pc=32'h4.
